// File: rtl/fsm_requester.sv
// Initiator-side request/acknowledge controller: one outstanding core transaction, pushed to the dispatcher queue.
// Optional ACK_TIMEOUT_EN adds WAIT_ACK timeout with bounded re-issue and an error response.
module fsm_requester #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Pwr_off,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              RspErr,
  input  logic              IsFull,
  output logic              PushEn,
  output logic [ADDR_W-1:0] PushAddr,
  output logic [DATA_W-1:0] PushData,
  output logic              WriteOp,
  output logic [1:0]        DirtyVal,
  input  logic              Ack,
  input  logic [DATA_W-1:0] AckData
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t            stateReg;
  state_t            stateNext;

  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] dataReg;
  logic              writeReg;
  logic [1:0]        dirtyReg;
  logic [DATA_W-1:0] rspDataReg;
  logic              rspErrReg;

  logic              acceptReq;
  logic              ackTaken;

  assign acceptReq = ReqReady && ReqValid;
  assign ackTaken  = (stateReg == WAIT_ACK) && Ack && !Pwr_off;

`ifdef ACK_TIMEOUT_EN
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;

  logic [CNT_W-1:0]   cntReg;
  logic [RETRY_W-1:0] retryReg;
  logic               timeoutHit;
  logic               retryLeft;

  // Ack in the same cycle as the last timeout count takes priority.
  assign timeoutHit = (stateReg == WAIT_ACK) && !Ack && !Pwr_off &&
                      (cntReg == CNT_W'(TIMEOUT - 1));
  assign retryLeft  = (retryReg < RETRY_W'(MAX_RETRY));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cntReg   <= '0;
      retryReg <= '0;
    end else begin
      // Counter is held at zero outside WAIT_ACK, so each entry starts fresh.
      if (stateReg == WAIT_ACK && !Pwr_off)
        cntReg <= cntReg + CNT_W'(1);
      else
        cntReg <= '0;
      if (acceptReq)
        retryReg <= '0;
      else if (timeoutHit && retryLeft)
        retryReg <= retryReg + RETRY_W'(1);
    end
  end
`else
  logic unusedCfg;
  assign unusedCfg = (TIMEOUT > 0) ^ (MAX_RETRY > 0);
`endif

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      stateReg <= IDLE;
    else
      stateReg <= stateNext;
  end

  // Next-state logic; power-off overrides every state.
  always_comb begin
    stateNext = stateReg;
    if (Pwr_off) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE:     if (acceptReq) stateNext = ISSUE;
        ISSUE:    if (!IsFull)   stateNext = WAIT_ACK;
        WAIT_ACK: begin
          if (Ack)
            stateNext = RESP;
`ifdef ACK_TIMEOUT_EN
          else if (timeoutHit)
            stateNext = retryLeft ? ISSUE : RESP;
`endif
        end
        RESP:     stateNext = IDLE;
        default:  stateNext = IDLE;
      endcase
    end
  end

  // Output logic; reset low forces every strobe and ReqReady to zero.
  always_comb begin
    ReqReady = 1'b0;
    PushEn   = 1'b0;
    RspValid = 1'b0;
    if (Rst && !Pwr_off) begin
      case (stateReg)
        IDLE:    ReqReady = 1'b1;
        ISSUE:   PushEn   = !IsFull;
        RESP:    RspValid = 1'b1;
        default: ;
      endcase
    end
  end

  // Request word and response registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      addrReg    <= '0;
      dataReg    <= '0;
      writeReg   <= 1'b0;
      dirtyReg   <= 2'd0;
      rspDataReg <= '0;
      rspErrReg  <= 1'b0;
    end else begin
      if (acceptReq) begin
        addrReg  <= ReqAddr;
        dataReg  <= ReqData;
        writeReg <= ReqWrite;
        dirtyReg <= ReqWrite ? 2'd3 : 2'd2;
      end
      if (ackTaken) begin
        rspDataReg <= writeReg ? '0 : AckData;
        rspErrReg  <= 1'b0;
      end
`ifdef ACK_TIMEOUT_EN
      else if (timeoutHit && !retryLeft) begin
        rspDataReg <= '0;
        rspErrReg  <= 1'b1;
      end
`endif
    end
  end

  assign PushAddr = addrReg;
  assign PushData = dataReg;
  assign WriteOp  = writeReg;
  assign DirtyVal = dirtyReg;
  assign RspData  = rspDataReg;
  assign RspErr   = rspErrReg;

endmodule

// File: tb/tb_fsm_requester.sv
// Directed self-checking bench for fsm_requester; build with +define+ACK_TIMEOUT_EN to exercise the timeout path.
module tb_fsm_requester;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              Pwr_off = 1'b0;
  logic              ReqValid = 1'b0;
  logic              ReqReady;
  logic              ReqWrite = 1'b0;
  logic [ADDR_W-1:0] ReqAddr = '0;
  logic [DATA_W-1:0] ReqData = '0;
  logic              RspValid;
  logic [DATA_W-1:0] RspData;
  logic              RspErr;
  logic              IsFull = 1'b0;
  logic              PushEn;
  logic [ADDR_W-1:0] PushAddr;
  logic [DATA_W-1:0] PushData;
  logic              WriteOp;
  logic [1:0]        DirtyVal;
  logic              Ack = 1'b0;
  logic [DATA_W-1:0] AckData = '0;

  int tests = 0;
  int fails = 0;

  fsm_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4), .MAX_RETRY(1)) dut (
    .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
    .IsFull(IsFull), .PushEn(PushEn), .PushAddr(PushAddr), .PushData(PushData),
    .WriteOp(WriteOp), .DirtyVal(DirtyVal), .Ack(Ack), .AckData(AckData)
  );

  always #5 Clk = ~Clk;

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (ReqReady !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ReqReady); end
    tests++; if ({PushEn, RspValid, RspErr, WriteOp, DirtyVal} !== 6'b0) begin fails++; $display("FAIL reset_ctrl got %b exp 0", {PushEn, RspValid, RspErr, WriteOp, DirtyVal}); end
    tests++; if ({PushAddr, PushData, RspData} !== '0) begin fails++; $display("FAIL reset_data got %h exp 0", {PushAddr, PushData, RspData}); end
    tick(); tick();
    Rst = 1'b1;
    #1;
    tests++; if (ReqReady !== 1'b1) begin fails++; $display("FAIL idle_ready got %b exp 1", ReqReady); end
    $display("[TB] reset done");
  endtask

  task automatic test_read();
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h100; ReqData = 32'h0;
    tick();
    ReqValid = 1'b0;
    #1;
    tests++; if (PushEn !== 1'b1) begin fails++; $display("FAIL rd_push got %b exp 1", PushEn); end
    tests++; if ({WriteOp, DirtyVal} !== 3'b010) begin fails++; $display("FAIL rd_word got %b exp 010", {WriteOp, DirtyVal}); end
    tests++; if (PushAddr !== 32'h100) begin fails++; $display("FAIL rd_addr got %h exp 100", PushAddr); end
    tests++; if (ReqReady !== 1'b0) begin fails++; $display("FAIL rd_busy got %b exp 0", ReqReady); end
    tick(); // push +1
    #1;
    tests++; if (PushEn !== 1'b0) begin fails++; $display("FAIL rd_push_once got %b exp 0", PushEn); end
    tick(); // push +2
    tick(); // push +3
    Ack = 1'b1; AckData = 32'hDEADBEEF;
    #1;
    tests++; if (RspValid !== 1'b0) begin fails++; $display("FAIL rd_early_rsp got %b exp 0", RspValid); end
    tick();
    Ack = 1'b0; AckData = 32'h0;
    #1;
    tests++; if ({RspValid, RspErr} !== 2'b10) begin fails++; $display("FAIL rd_rsp got %b exp 10", {RspValid, RspErr}); end
    tests++; if (RspData !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_rspdata got %h exp deadbeef", RspData); end
    tests++; if (WriteOp !== 1'b0 || DirtyVal !== 2'd2 || PushAddr !== 32'h100) begin fails++; $display("FAIL rd_word_stable got %b/%0d/%h exp 0/2/100", WriteOp, DirtyVal, PushAddr); end
    tick();
    #1;
    tests++; if ({RspValid, ReqReady} !== 2'b01) begin fails++; $display("FAIL rd_back_idle got %b exp 01", {RspValid, ReqReady}); end
    tests++; if (RspData !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_rsp_hold got %h exp deadbeef", RspData); end
    $display("[TB] read addr=100 rsp=%h", RspData);
  endtask

  task automatic test_write();
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h200; ReqData = 32'h55;
    tick();
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqData = 32'h0;
    #1;
    tests++; if (PushEn !== 1'b1) begin fails++; $display("FAIL wr_push got %b exp 1", PushEn); end
    tests++; if ({WriteOp, DirtyVal} !== 3'b111) begin fails++; $display("FAIL wr_word got %b exp 111", {WriteOp, DirtyVal}); end
    tests++; if (PushData !== 32'h55 || PushAddr !== 32'h200) begin fails++; $display("FAIL wr_data got %h/%h exp 55/200", PushData, PushAddr); end
    tick();
    Ack = 1'b1; AckData = 32'hCAFEF00D;
    tick();
    Ack = 1'b0;
    #1;
    tests++; if (RspValid !== 1'b1) begin fails++; $display("FAIL wr_rsp got %b exp 1", RspValid); end
    tests++; if (RspData !== 32'h0) begin fails++; $display("FAIL wr_rspdata got %h exp 0", RspData); end
    tick();
    $display("[TB] write addr=200 data=55 rsp=%h", RspData);
  endtask

  task automatic test_backpressure();
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h300; IsFull = 1'b1;
    tick();
    ReqValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if ({PushEn, ReqReady} !== 2'b00) begin fails++; $display("FAIL bp_hold%0d got %b exp 00", i, {PushEn, ReqReady}); end
      tick();
    end
    IsFull = 1'b0;
    #1;
    tests++; if ({PushEn, ReqReady} !== 2'b10) begin fails++; $display("FAIL bp_release got %b exp 10", {PushEn, ReqReady}); end
    tick();
    #1;
    tests++; if ({PushEn, ReqReady} !== 2'b00) begin fails++; $display("FAIL bp_single got %b exp 00", {PushEn, ReqReady}); end
    Ack = 1'b1; AckData = 32'h1234;
    tick();
    Ack = 1'b0;
    #1;
    tests++; if (RspValid !== 1'b1 || RspData !== 32'h1234) begin fails++; $display("FAIL bp_rsp got %b/%h exp 1/1234", RspValid, RspData); end
    tick();
    $display("[TB] backpressure addr=300 rsp=%h", RspData);
  endtask

  task automatic test_abort();
    Pwr_off = 1'b1; ReqValid = 1'b1; ReqAddr = 32'h400;
    #1;
    tests++; if (ReqReady !== 1'b0) begin fails++; $display("FAIL pwr_idle_ready got %b exp 0", ReqReady); end
    tick();
    Pwr_off = 1'b0;
    #1;
    tests++; if ({ReqReady, PushEn} !== 2'b10) begin fails++; $display("FAIL pwr_no_accept got %b exp 10", {ReqReady, PushEn}); end
    tick(); // ISSUE
    ReqValid = 1'b0;
    tick(); // WAIT_ACK
    Pwr_off = 1'b1;
    #1;
    tests++; if ({ReqReady, PushEn, RspValid} !== 3'b000) begin fails++; $display("FAIL abort_cycle got %b exp 000", {ReqReady, PushEn, RspValid}); end
    tick();
    Pwr_off = 1'b0; Ack = 1'b1; AckData = 32'h0BAD;
    #1;
    tests++; if ({ReqReady, RspValid} !== 2'b10) begin fails++; $display("FAIL abort_idle got %b exp 10", {ReqReady, RspValid}); end
    tick();
    Ack = 1'b0;
    #1;
    tests++; if ({ReqReady, RspValid} !== 2'b10) begin fails++; $display("FAIL abort_late_ack got %b exp 10", {ReqReady, RspValid}); end
    tests++; if (RspData !== 32'h1234) begin fails++; $display("FAIL abort_rspdata got %h exp 1234", RspData); end
    $display("[TB] abort addr=400 dropped");
  endtask

  task automatic test_timeout();
    int pushes;
    int rsps;
    logic errSeen;
    pushes = 0; rsps = 0; errSeen = 1'b0;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h500;
    tick();
    ReqValid = 1'b0;
`ifdef ACK_TIMEOUT_EN
    for (int i = 0; i < 30 && rsps == 0; i++) begin
      #1;
      if (PushEn) pushes++;
      if (RspValid) begin rsps++; errSeen = RspErr; end
      tick();
    end
    tests++; if (pushes !== 2) begin fails++; $display("FAIL to_pushes got %0d exp 2", pushes); end
    tests++; if (rsps !== 1 || errSeen !== 1'b1) begin fails++; $display("FAIL to_err got rsp=%0d err=%b exp 1/1", rsps, errSeen); end
    tests++; if (RspData !== 32'h0) begin fails++; $display("FAIL to_rspdata got %h exp 0", RspData); end
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      if (PushEn) pushes++;
      if (RspValid) rsps++;
      tick();
    end
    tests++; if (pushes !== 1 || rsps !== 0) begin fails++; $display("FAIL noto_wait got push=%0d rsp=%0d exp 1/0", pushes, rsps); end
    Ack = 1'b1; AckData = 32'h7777;
    tick();
    Ack = 1'b0;
    #1;
    tests++; if ({RspValid, RspErr} !== 2'b10 || RspData !== 32'h7777) begin fails++; $display("FAIL noto_rsp got %b/%h exp 10/7777", {RspValid, RspErr}, RspData); end
    tick();
`endif
    #1;
    tests++; if (ReqReady !== 1'b1) begin fails++; $display("FAIL to_idle got %b exp 1", ReqReady); end
    $display("[TB] timeout scenario pushes=%0d rsps=%0d", pushes, rsps);
  endtask

  task automatic test_async_reset();
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h600; ReqData = 32'hAA; IsFull = 1'b1;
    tick(); // ISSUE, held by IsFull
    ReqValid = 1'b0;
    #1;
    tests++; if (PushAddr !== 32'h600 || ReqReady !== 1'b0) begin fails++; $display("FAIL ar_pre got %h/%b exp 600/0", PushAddr, ReqReady); end
    IsFull = 1'b0;
    Rst = 1'b0;
    #1;
    tests++; if ({ReqReady, PushEn, RspValid, RspErr, WriteOp, DirtyVal} !== 7'b0) begin fails++; $display("FAIL ar_ctrl got %b exp 0", {ReqReady, PushEn, RspValid, RspErr, WriteOp, DirtyVal}); end
    tests++; if ({PushAddr, PushData, RspData} !== '0) begin fails++; $display("FAIL ar_data got %h exp 0", {PushAddr, PushData, RspData}); end
    tick();
    Rst = 1'b1;
    #1;
    tests++; if ({ReqReady, PushEn, RspValid} !== 3'b100) begin fails++; $display("FAIL ar_idle got %b exp 100", {ReqReady, PushEn, RspValid}); end
    tick();
    #1;
    tests++; if ({ReqReady, RspValid} !== 2'b10) begin fails++; $display("FAIL ar_no_rsp got %b exp 10", {ReqReady, RspValid}); end
    $display("[TB] async reset during ISSUE");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_abort();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
